bist_controller: RTL

Sequencer for the per-scan BIST loop. On `start` it loads a pseudo-random pattern generator, shifts patterns into the circuit-under-test scan chain, and pulses capture. It holds the 16-bit signature compactor in reset through the first load, so only CUT responses are compacted. After the final unload it samples the compactor's pass/fail flag in the single cycle the signature is valid, and latches a verdict. It sits between the top-level test access and the CUT scan chain plus signature compactor.

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_prpg.sv | 45 ++++
 rtl/bist_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: FSM states, generator taps and
// the signature width that the compactor also uses.
package bist_pkg;

  localparam int SIG_BITS = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [SIG_BITS-1:0] PRPG_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_COMPARE,
    S_DONE
  } state_t;

  function automatic logic [SIG_BITS-1:0] prpg_step(input logic [SIG_BITS-1:0] s);
    return {s[SIG_BITS-2:0], ^(s & PRPG_TAPS)};
  endfunction

endpackage

// File: rtl/bist_prpg.sv
// Fibonacci pattern generator with a registered serial output, so the bit on
// scan_in always matches the generator state of the current shift cycle.
module bist_prpg
  import bist_pkg::*;
#(
  parameter logic [SIG_BITS-1:0] SEED = 16'hACE1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_step,
  input  logic i_out_en,
  output logic o_serial
);

  logic [SIG_BITS-1:0] r_lfsr;
  logic [SIG_BITS-1:0] w_lfsr_next;
  logic                r_serial;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_lfsr_next = r_lfsr;
    if (i_load) begin
      w_lfsr_next = SEED;
    end else if (i_step) begin
      w_lfsr_next = prpg_step(r_lfsr);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr   <= SEED;
      r_serial <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_serial <= i_out_en ? w_lfsr_next[SIG_BITS-1] : 1'b0;
    end
  end

  assign o_serial = r_serial;

endmodule

// File: rtl/bist_controller.sv
// Per-scan BIST sequencer: loads the generator, shifts and captures patterns,
// unloads the last response and latches the compactor verdict.
module bist_controller
  import bist_pkg::*;
#(
  parameter int                  SCAN_LENGTH  = 8,
  parameter int                  NUM_PATTERNS = 32,
  parameter logic [SIG_BITS-1:0] PRPG_SEED    = 16'hACE1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic misr_pass_nfail,
  output logic scan_en,
  output logic scan_in,
  output logic misr_reset,
  output logic busy,
  output logic done,
  output logic pass
);

  localparam int                BIT_W    = $clog2(SCAN_LENGTH);
  localparam int                PAT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SCAN_LENGTH - 1);
  localparam logic [PAT_W-1:0]  PAT_ALL  = PAT_W'(NUM_PATTERNS);

  state_t             r_state, w_state_next;
  logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [PAT_W-1:0]   r_pat_cnt, w_pat_cnt_next;
  logic               r_scan_en, r_misr_reset, r_busy, r_done, r_pass;
  logic               w_scan_en_next, w_misr_reset_next, w_busy_next;

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_pat_cnt_next = r_pat_cnt;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_INIT;
      S_INIT: begin
        w_bit_cnt_next = '0;
        w_pat_cnt_next = '0;
        w_state_next   = S_SHIFT;
      end
      S_SHIFT, S_UNLOAD: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_next = '0;
          w_state_next   = (r_state == S_SHIFT) ? S_CAPTURE : S_COMPARE;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_pat_cnt_next = r_pat_cnt + 1'b1;
        w_state_next   = (w_pat_cnt_next < PAT_ALL) ? S_SHIFT : S_UNLOAD;
      end
      S_COMPARE: w_state_next = S_DONE;
      S_DONE:    if (!start) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (abort) w_state_next = S_IDLE;
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    w_scan_en_next    = (w_state_next inside {S_SHIFT, S_UNLOAD});
    w_busy_next       = (w_state_next inside {S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE});
    w_misr_reset_next = (w_state_next inside {S_IDLE, S_INIT}) ||
                        ((w_state_next inside {S_SHIFT, S_CAPTURE}) && (w_pat_cnt_next == '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_pat_cnt    <= '0;
      r_scan_en    <= 1'b0;
      r_misr_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_pat_cnt    <= w_pat_cnt_next;
      r_scan_en    <= w_scan_en_next;
      r_misr_reset <= w_misr_reset_next;
      r_busy       <= w_busy_next;
      if (abort) begin
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else begin
        if (w_state_next == S_DONE)      r_done <= 1'b1;
        else if (w_state_next == S_INIT) r_done <= 1'b0;
        // The compactor has no enable: COMPARE is its only valid signature cycle.
        if (r_state == S_COMPARE)        r_pass <= misr_pass_nfail;
        else if (w_state_next == S_INIT) r_pass <= 1'b0;
      end
    end
  end

  bist_prpg #(
    .SEED (PRPG_SEED)
  ) u_prpg (
    .clock    (clock),
    .reset    (reset),
    .i_load   (r_state == S_INIT),
    .i_step   (r_state inside {S_SHIFT, S_UNLOAD}),
    .i_out_en (w_scan_en_next),
    .o_serial (scan_in)
  );

  assign scan_en    = r_scan_en;
  assign misr_reset = r_misr_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;

endmodule
